btb_predictor: RTL and testbench
================================

BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/PC width.
REQ-002 SHALL have parameter ENTRIES, default 16, table depth, power of 2, >=2; IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter CTR_W, default 2, saturating-counter width, >=1.
REQ-004 SHALL have parameter TAG_W = XLEN-2-IDX_W (derived, not overridable).
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  clock, rising edge.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 flush  input  1  synchronous invalidate of all entries.
REQ-009 F_pc  input  XLEN  fetch PC to look up.
REQ-010 pred_hit  output  1  valid entry with matching tag.
REQ-011 pred_taken  output  1  predicted taken.
REQ-012 pred_target  output  XLEN  predicted next PC.
REQ-013 upd_en  input  1  E-stage resolved a jump/branch this cycle.
REQ-014 E_pc  input  XLEN  PC of resolved instruction.
REQ-015 E_taken  input  1  actual outcome (jumps drive 1).
REQ-016 E_target  input  XLEN  actual target (jb_pc).
REQ-017 E_pred_taken  input  1  prediction carried down the pipe for E_pc.
REQ-018 E_pred_target  input  XLEN  predicted target carried down the pipe.
REQ-019 mispredict  output  1  redirect request, combinational from E inputs.
REQ-020 branch_cnt  output  32  resolved-branch counter.
REQ-021 mispred_cnt  output  32  mispredict counter.

Function
REQ-022 SHALL index with idx = F_pc[IDX_W+1:2] and tag = F_pc[XLEN-1:IDX_W+2]; same slicing for E_pc on update.
REQ-023 SHALL drive pred_hit = valid[idx] & (tag_mem[idx]==tag), combinational, zero-cycle lookup.
REQ-024 SHALL drive pred_taken = pred_hit & ctr[idx][CTR_W-1].
REQ-025 SHALL drive pred_target = target[idx] when pred_taken, else F_pc+4 (wrap modulo 2^XLEN).
REQ-026 SHALL drive mispredict = upd_en & ((E_pred_taken!=E_taken) | (E_taken & E_pred_target!=E_target)).
REQ-027 On upd_en with E-hit: counter +1 if E_taken, -1 if not, saturating at 2^CTR_W-1 and 0; target written with E_target only if E_taken.
REQ-028 On upd_en with E-miss and E_taken: allocate entry: valid=1, tag, target=E_target, ctr=2^(CTR_W-1) (weakly taken); any prior occupant overwritten.
REQ-029 On upd_en with E-miss and not E_taken: no table change.
REQ-030 Lookup and update to same index in one cycle: lookup returns pre-update contents (no bypass); update visible next cycle.
REQ-031 flush SHALL clear all valid bits at the next edge; counters/targets/tags retained; flush wins over a same-cycle update (update dropped).
REQ-032 branch_cnt SHALL increment on every upd_en edge; mispred_cnt on every edge with mispredict; both wrap 2^32-1 -> 0; both still count when flush coincides.
REQ-033 pred_* outputs SHALL depend only on F_pc and table state, never on update inputs in the same cycle.

Reset
REQ-034 rst low SHALL immediately clear all valid bits, set every counter to 2^(CTR_W-1)-1 (weakly not-taken), targets/tags to 0, branch_cnt=mispred_cnt=0.
REQ-035 During reset pred_hit=0, pred_taken=0, pred_target=F_pc+4; upd_en ignored.
REQ-036 Reset asserted mid-update SHALL discard that update; state is reset values on release.

Verification
REQ-037 After reset, F_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104.
REQ-038 upd_en, E_pc=0x100, E_taken=1, E_target=0x200, E_pred_taken=0 -> mispredict=1; next cycle F_pc=0x100 gives hit=1, taken=1, target=0x200; mispred_cnt=1, branch_cnt=1.
REQ-039 Same entry, three not-taken updates (CTR_W=2): counter 2->1->0->0 saturates; pred_taken=0 after first; four taken updates return 0->3 saturate, pred_taken=1 from count 2.
REQ-040 ENTRIES=16: allocate 0x100 then 0x140 (same idx, different tag) -> 0x100 now misses, 0x140 hits.
REQ-041 flush and upd_en allocating 0x300 same cycle -> all entries invalid next cycle incl. 0x300; branch_cnt still increments.
REQ-042 Preload mispred_cnt to 0xFFFFFFFF via updates/force, one more mispredict -> 0x00000000; rst asserted asynchronously mid-cycle -> outputs to reset values before next edge.

Source files
------------

// File: rtl/btb_predictor.sv
// Branch target buffer with per-entry saturating direction counters.
// Lookup is purely combinational from the fetch PC; training happens at the
// clock edge from the execute-stage resolution. Resolved-branch and
// mispredict event counters are included for performance monitoring.
module btb_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [XLEN-1:0] F_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_en,
  input  logic [XLEN-1:0] E_pc,
  input  logic            E_taken,
  input  logic [XLEN-1:0] E_target,
  input  logic            E_pred_taken,
  input  logic [XLEN-1:0] E_pred_target,
  output logic            mispredict,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - 2 - IDX_W;

  // Counter encodings: MSB set means "predict taken".
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [XLEN-1:0]    target_mem [ENTRIES];
  logic [CTR_W-1:0]   ctr_mem    [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic             e_hit;
  logic [CTR_W-1:0] e_ctr;

  // Instructions are word aligned, so the two PC LSBs never select anything.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{F_pc[1:0], E_pc[1:0]};

  assign f_idx = F_pc[IDX_W+1:2];
  assign f_tag = F_pc[XLEN-1:IDX_W+2];
  assign e_idx = E_pc[IDX_W+1:2];
  assign e_tag = E_pc[XLEN-1:IDX_W+2];

  // Fetch lookup: reads table state only, never the same-cycle update inputs.
  always_comb begin
    pred_hit    = valid[f_idx] && (tag_mem[f_idx] == f_tag);
    pred_taken  = pred_hit && ctr_mem[f_idx][CTR_W-1];
    pred_target = pred_taken ? target_mem[f_idx] : F_pc + XLEN'(4);
  end

  // Execute-side hit detection and redirect request.
  always_comb begin
    e_hit      = valid[e_idx] && (tag_mem[e_idx] == e_tag);
    e_ctr      = ctr_mem[e_idx];
    mispredict = upd_en && ((E_pred_taken != E_taken) ||
                            (E_taken && (E_pred_target != E_target)));
  end

  // Table training; flush invalidates everything and drops a concurrent update.
  // NOTE: the table is built from flops rather than a RAM macro, which is what
  // allows every entry to be cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_mem[i]    <= '0;
        target_mem[i] <= '0;
        ctr_mem[i]    <= CTR_WNT;
      end
    end else if (flush) begin
      valid <= '0;
    end else if (upd_en) begin
      if (e_hit) begin
        if (E_taken) begin
          target_mem[e_idx] <= E_target;
          if (e_ctr != CTR_MAX) ctr_mem[e_idx] <= e_ctr + CTR_W'(1);
        end else if (e_ctr != '0) begin
          ctr_mem[e_idx] <= e_ctr - CTR_W'(1);
        end
      end else if (E_taken) begin
        valid[e_idx]      <= 1'b1;
        tag_mem[e_idx]    <= e_tag;
        target_mem[e_idx] <= E_target;
        ctr_mem[e_idx]    <= CTR_WT;
      end
    end
  end

  // Event counters; they keep counting through a flush and wrap naturally.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (upd_en)     branch_cnt  <= branch_cnt + 32'd1;
      if (mispredict) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed scoreboard bench for btb_predictor: the stimulus process pushes the
// hand-computed response for each cycle, and a negedge monitor pops and compares.
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] F_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_en;
  logic [31:0] E_pc;
  logic        E_taken;
  logic [31:0] E_target;
  logic        E_pred_taken;
  logic [31:0] E_pred_target;
  logic        mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  btb_predictor #(.XLEN(32), .ENTRIES(16), .CTR_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .F_pc(F_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_en(upd_en), .E_pc(E_pc), .E_taken(E_taken), .E_target(E_target),
    .E_pred_taken(E_pred_taken), .E_pred_target(E_pred_target),
    .mispredict(mispredict), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    logic        misp;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] bcnt = 0;
  logic [31:0] mcnt = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, want);
    end
  endtask

  // Monitor: compare whatever the stimulus expects for the current cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({e.nm, ".hit"},    32'(pred_hit),    32'(e.hit));
      check({e.nm, ".taken"},  32'(pred_taken),  32'(e.taken));
      check({e.nm, ".target"}, pred_target,      e.tgt);
      check({e.nm, ".misp"},   32'(mispredict),  32'(e.misp));
      check({e.nm, ".bcnt"},   branch_cnt,       e.bc);
      check({e.nm, ".mcnt"},   mispred_cnt,      e.mc);
    end
  end

  task automatic push(input string nm, input logic xh, input logic xt,
                      input logic [31:0] xtgt, input logic xm);
    exp_t e;
    e.nm = nm; e.hit = xh; e.taken = xt; e.tgt = xtgt; e.misp = xm;
    e.bc = bcnt; e.mc = mcnt;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [31:0] fpc, input logic upd, input logic [31:0] epc,
                       input logic et, input logic [31:0] etgt, input logic ept,
                       input logic [31:0] eptgt, input logic fl);
    F_pc = fpc; upd_en = upd; E_pc = epc; E_taken = et; E_target = etgt;
    E_pred_taken = ept; E_pred_target = eptgt; flush = fl;
  endtask

  // One cycle: drive, push the expected response, advance past the edge.
  task automatic step(input string nm, input logic [31:0] fpc, input logic upd,
                      input logic [31:0] epc, input logic et, input logic [31:0] etgt,
                      input logic ept, input logic [31:0] eptgt, input logic fl,
                      input logic xh, input logic xt, input logic [31:0] xtgt,
                      input logic xm);
    drive(fpc, upd, epc, et, etgt, ept, eptgt, fl);
    push(nm, xh, xt, xtgt, xm);
    @(posedge clk);
    #1;
    if (upd) bcnt = bcnt + 32'd1;
    if (xm)  mcnt = mcnt + 32'd1;
  endtask

  initial begin
    // Reset held: an update that would allocate 0x100 must be ignored.
    rst = 1'b0;
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
    push("in_reset", 1'b0, 1'b0, 32'h104, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    //    name        F_pc          upd  E_pc      Et   E_tgt     Ept  Ept_tgt  fl    hit  tkn  target         misp
    step("alloc",     32'h100,      1,   32'h100,  1,   32'h200,  0,   32'h0,   0,    0,   0,   32'h104,       1);
    step("nt1",       32'h100,      1,   32'h100,  0,   32'h0,    1,   32'h200, 0,    1,   1,   32'h200,       1);
    step("nt2",       32'h100,      1,   32'h100,  0,   32'h0,    0,   32'h0,   0,    1,   0,   32'h104,       0);
    step("nt3_sat",   32'h100,      1,   32'h100,  0,   32'h0,    0,   32'h0,   0,    1,   0,   32'h104,       0);
    step("t1",        32'h100,      1,   32'h100,  1,   32'h200,  0,   32'h0,   0,    1,   0,   32'h104,       1);
    step("t2",        32'h100,      1,   32'h100,  1,   32'h200,  0,   32'h0,   0,    1,   0,   32'h104,       1);
    step("t3",        32'h100,      1,   32'h100,  1,   32'h200,  1,   32'h200, 0,    1,   1,   32'h200,       0);
    step("t4_sat",    32'h100,      1,   32'h100,  1,   32'h200,  1,   32'h200, 0,    1,   1,   32'h200,       0);
    step("tgt_chg",   32'h100,      1,   32'h100,  1,   32'h280,  1,   32'h200, 0,    1,   1,   32'h200,       1);
    step("dn_from3",  32'h100,      1,   32'h100,  0,   32'h0,    1,   32'h280, 0,    1,   1,   32'h280,       1);
    step("alias",     32'h100,      1,   32'h140,  1,   32'h500,  0,   32'h0,   0,    1,   1,   32'h280,       1);
    step("old_miss",  32'h100,      0,   32'h0,    0,   32'h0,    0,   32'h0,   0,    0,   0,   32'h104,       0);
    step("new_hit",   32'h140,      1,   32'h180,  0,   32'h0,    0,   32'h0,   0,    1,   1,   32'h500,       0);
    step("flush_upd", 32'h140,      1,   32'h304,  1,   32'h600,  0,   32'h0,   1,    1,   1,   32'h500,       1);
    step("fl_140",    32'h140,      0,   32'h0,    0,   32'h0,    0,   32'h0,   0,    0,   0,   32'h144,       0);
    step("fl_304",    32'h304,      0,   32'h0,    0,   32'h0,    0,   32'h0,   0,    0,   0,   32'h308,       0);
    step("pc_wrap",   32'hFFFFFFFC, 1,   32'h140,  1,   32'h500,  0,   32'h0,   0,    0,   0,   32'h0,         1);
    step("realloc",   32'h140,      0,   32'h0,    0,   32'h0,    0,   32'h0,   0,    1,   1,   32'h500,       0);

    // Preload the mispredict counter just below wrap, then one more mispredict.
    force dut.mispred_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.mispred_cnt;
    mcnt = 32'hFFFF_FFFF;
    step("cnt_max",   32'h140,      1,   32'h140,  0,   32'h0,    1,   32'h500, 0,    1,   1,   32'h500,       1);
    step("cnt_wrap",  32'h140,      0,   32'h0,    0,   32'h0,    0,   32'h0,   0,    1,   0,   32'h144,       0);

    // Asynchronous reset mid-cycle with an allocating update pending.
    drive(32'h140, 1'b1, 32'h304, 1'b1, 32'h600, 1'b1, 32'h600, 1'b0);
    #1;
    rst = 1'b0;
    bcnt = 0;
    mcnt = 0;
    push("async_rst", 1'b0, 1'b0, 32'h144, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("post_140",  32'h140,      0,   32'h0,    0,   32'h0,    0,   32'h0,   0,    0,   0,   32'h144,       0);
    step("post_304",  32'h304,      0,   32'h0,    0,   32'h0,    0,   32'h0,   0,    0,   0,   32'h308,       0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
